// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the scan_decoder block.
//   state_e   : operating state (OFF / DIRECT / SCAN)
//   onehot()  : binary index to one-hot vector, MAX_OUT_W wide; callers cast
//               the result down to their own output width.
package scan_decoder_pkg;

    localparam int unsigned MAX_SEL_W = 8;
    localparam int unsigned MAX_OUT_W = 1 << MAX_SEL_W;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_e;

    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
        logic [MAX_OUT_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// Control/status bundle for scan_decoder.
//   master : drives en, mode, sel, load, dwell (and dir), observes y, idx, wrap
//   slave  : the decoder side
// Optional macro SCAN_DECODER_REVERSE_EN adds the dir signal.
interface scan_decoder_if #(
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned DWELL_W = 8
);
    localparam int unsigned OUT_W = 1 << SEL_W;

    logic               en;
    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic               load;
    logic [DWELL_W-1:0] dwell;
`ifdef SCAN_DECODER_REVERSE_EN
    logic               dir;
`endif
    logic [OUT_W-1:0]   y;
    logic [SEL_W-1:0]   idx;
    logic               wrap;

    modport master (
        output en, mode, sel, load, dwell,
`ifdef SCAN_DECODER_REVERSE_EN
        output dir,
`endif
        input  y, idx, wrap
    );

    modport slave (
        input  en, mode, sel, load, dwell,
`ifdef SCAN_DECODER_REVERSE_EN
        input  dir,
`endif
        output y, idx, wrap
    );

endinterface

// File: rtl/scan_decoder_dwell_counter.sv
// Dwell counter for scan mode.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (has priority)
//   dwell      : live terminal value (hold time minus one)
//   term_c     : combinational terminal count; also true when the count has
//                overshot a freshly lowered dwell, so the caller advances
//                instead of waiting for a counter wrap.
module dwell_counter #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic [DWELL_W-1:0] dwell,
    output logic               term_c
);

    logic [DWELL_W-1:0] cnt_q, cnt_d;

    assign term_c = (cnt_q >= dwell);

    // Restart on clear or on reaching the terminal count.
    always_comb begin
        cnt_d = cnt_q + DWELL_W'(1);
        if (clr || term_c) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered binary-to-one-hot decoder with auto-scan mode.
//   clk, rst_n : clock, async active-low reset
//   bus        : scan_decoder_if.slave
//                en=0 forces y low; mode 0 = direct decode of sel,
//                mode 1 = scan starting at sel, restarted by load,
//                each position held dwell+1 cycles; wrap pulses on scan wrap.
// Optional macro SCAN_DECODER_REVERSE_EN: bus.dir=1 scans downward.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned DWELL_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    scan_decoder_if.slave  bus
);

    localparam int unsigned OUT_W = 1 << SEL_W;

    state_e            state_q, state_d;
    logic [OUT_W-1:0]  y_q, y_d;
    logic [SEL_W-1:0]  idx_q, idx_d;
    logic              wrap_q, wrap_d;
    logic              cnt_clr_c;
    logic              term_c;

    dwell_counter #(.DWELL_W(DWELL_W)) u_dwell_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr_c),
        .dwell  (bus.dwell),
        .term_c (term_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: en and mode select the state directly.
    always_comb begin
        state_d = state_q;
        if (!bus.en) begin
            state_d = OFF;
        end else if (!bus.mode) begin
            state_d = DIRECT;
        end else begin
            state_d = SCAN;
        end
    end

    // Next outputs and counter control.
    always_comb begin
        idx_d     = idx_q;
        y_d       = '0;
        wrap_d    = 1'b0;
        cnt_clr_c = 1'b1;
        case (state_d)
            DIRECT: begin
                idx_d = bus.sel;
                y_d   = OUT_W'(onehot(MAX_SEL_W'(idx_d)));
            end
            SCAN: begin
                // Entry or load restarts at sel; load beats a terminal count.
                if (state_q != SCAN || bus.load) begin
                    idx_d = bus.sel;
                end else begin
                    cnt_clr_c = 1'b0;
                    if (term_c) begin
`ifdef SCAN_DECODER_REVERSE_EN
                        if (bus.dir) begin
                            idx_d  = idx_q - SEL_W'(1);
                            wrap_d = (idx_q == '0);
                        end else begin
                            idx_d  = idx_q + SEL_W'(1);
                            wrap_d = (idx_q == SEL_W'(OUT_W - 1));
                        end
`else
                        idx_d  = idx_q + SEL_W'(1);
                        wrap_d = (idx_q == SEL_W'(OUT_W - 1));
`endif
                    end
                end
                y_d = OUT_W'(onehot(MAX_SEL_W'(idx_d)));
            end
            default: begin
                idx_d = idx_q;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q    <= '0;
            idx_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            y_q    <= y_d;
            idx_q  <= idx_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.y    = y_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;

endmodule
